stage_fetch: RTL and testbench

- Fetch stage of the 5-stage pipelined processor; sits directly upstream of stage_decode.
- Owns the PC register, drives the instruction-memory address, and holds the F/D pipeline latch.
- stage_decode takes its opcode/rd/rs/rt/ALU_op fields from that latch.
- Accepts a redirect (taken branch / jump / jr / bex) from execute and a load-use stall from hazard control; inserts NOPs on flush.

---
 rtl/proc_pkg.sv | 21 ++
 rtl/fd_latch.sv | 29 ++
 rtl/stage_fetch.sv | 59 +++++
 tb/tb_stage_fetch.sv | 138 +++++++++++++
 4 files changed

// File: rtl/proc_pkg.sv
// proc_pkg: shared processor constants (NOP encoding, opcodes, instruction fields, default PC width)
package proc_pkg;
    localparam int DEF_PC_W = 12;
    localparam logic [31:0] NOP_INSN = 32'b0;
    localparam logic [4:0] R_TYPE = 5'b00000;
    localparam logic [4:0] J      = 5'b00001;
    localparam logic [4:0] BNE    = 5'b00010;
    localparam logic [4:0] JAL    = 5'b00011;
    localparam logic [4:0] JR     = 5'b00100;
    localparam logic [4:0] ADDI   = 5'b00101;
    localparam logic [4:0] BLT    = 5'b00110;
    localparam logic [4:0] SW     = 5'b00111;
    localparam logic [4:0] LW     = 5'b01000;
    localparam logic [4:0] SETX   = 5'b10101;
    localparam logic [4:0] BEX    = 5'b10110;
    localparam int OPCODE_HI = 31, OPCODE_LO = 27;
    localparam int RD_HI = 26, RD_LO = 22;
    localparam int RS_HI = 21, RS_LO = 17;
    localparam int RT_HI = 16, RT_LO = 12;
    localparam int ALU_OP_HI = 6, ALU_OP_LO = 2;
endpackage

// File: rtl/fd_latch.sv
// fd_latch: F/D pipeline register; flush inserts a NOP bubble, load captures the fetched instruction
module fd_latch
    import proc_pkg::*;
#(
    parameter int PC_W = DEF_PC_W
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            load,
    input  logic            flush,
    input  logic [31:0]     insn,
    input  logic [PC_W-1:0] pc,
    input  logic            valid,
    output logic [31:0]     fd_insn,
    output logic [PC_W-1:0] fd_pc,
    output logic            fd_valid
);
    always_ff @(posedge clock) begin
        if (reset || flush) begin
            fd_insn  <= NOP_INSN;
            fd_pc    <= '0;
            fd_valid <= 1'b0;
        end else if (load) begin
            fd_insn  <= insn;
            fd_pc    <= pc;
            fd_valid <= valid;
        end
    end
endmodule

// File: rtl/stage_fetch.sv
// stage_fetch: PC register, next-PC mux and F/D latch; FETCH_PERF_EN adds fetch/stall/flush counters
module stage_fetch
    import proc_pkg::*;
#(
    parameter int PC_W = DEF_PC_W,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic [PC_W-1:0] address_imem,
    input  logic [31:0]     q_imem,
    input  logic            stall,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic [31:0]     fd_insn,
    output logic [PC_W-1:0] fd_pc,
    output logic            fd_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     perf_fetched,
    output logic [31:0]     perf_stalls,
    output logic [31:0]     perf_flushes
`endif
);
    logic [PC_W-1:0] pc, pc_plus1;
    assign pc_plus1 = pc + PC_W'(1);
    assign address_imem = pc;
    // redirect outranks stall, so a flush is never lost behind a load-use hold
    always_ff @(posedge clock) begin
        pc <= reset ? RESET_PC : redirect ? redirect_pc : stall ? pc : pc_plus1;
    end
    fd_latch #(.PC_W(PC_W)) u_fd (
        .clock    (clock),
        .reset    (reset),
        .load     (!stall),
        .flush    (redirect),
        .insn     (q_imem),
        .pc       (pc_plus1),
        .valid    (1'b1),
        .fd_insn  (fd_insn),
        .fd_pc    (fd_pc),
        .fd_valid (fd_valid)
    );
`ifdef FETCH_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_fetched <= '0;
            perf_stalls  <= '0;
            perf_flushes <= '0;
        end else if (redirect) begin
            perf_flushes <= perf_flushes + 32'd1;
        end else if (stall) begin
            perf_stalls <= perf_stalls + 32'd1;
        end else begin
            perf_fetched <= perf_fetched + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_stage_fetch.sv
// tb_stage_fetch: random and directed stimulus against a behavioural fetch model; FETCH_PERF_EN checks counters
module tb_stage_fetch;
    localparam int PC_W = 12;
    logic clock = 1'b0, reset = 1'b0, stall = 1'b0, redirect = 1'b0;
    logic [PC_W-1:0] address_imem, redirect_pc = '0, fd_pc;
    logic [31:0] q_imem, fd_insn;
    logic fd_valid;
    logic [31:0] imem [0:4095];
    int total = 0, bad = 0;
    int m_pc, m_fp;
    logic [31:0] m_fi;
    logic m_fv;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_stalls, perf_flushes;
    logic [31:0] m_nf, m_ns, m_nr;
`endif
    always #5 clock = ~clock;
    assign q_imem = imem[address_imem];
    stage_fetch #(.PC_W(PC_W), .RESET_PC('0)) dut (
        .clock(clock), .reset(reset), .address_imem(address_imem), .q_imem(q_imem),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .fd_insn(fd_insn), .fd_pc(fd_pc), .fd_valid(fd_valid)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_stalls(perf_stalls), .perf_flushes(perf_flushes)
`endif
    );
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask
    task automatic step(input logic rst, input logic st, input logic rd, input int rpc);
        reset = rst;
        stall = st;
        redirect = rd;
        redirect_pc = PC_W'(rpc);
        @(posedge clock);
        if (rst) begin
            m_pc = 0; m_fi = 0; m_fp = 0; m_fv = 0;
`ifdef FETCH_PERF_EN
            m_nf = 0; m_ns = 0; m_nr = 0;
`endif
        end else if (rd) begin
            m_pc = rpc % 4096; m_fi = 0; m_fp = 0; m_fv = 0;
`ifdef FETCH_PERF_EN
            m_nr++;
`endif
        end else if (st) begin
`ifdef FETCH_PERF_EN
            m_ns++;
`endif
        end else begin
            m_fi = imem[m_pc];
            m_pc = (m_pc + 1) % 4096;
            m_fp = m_pc;
            m_fv = 1;
`ifdef FETCH_PERF_EN
            m_nf++;
`endif
        end
        #1;
        check("address_imem", 32'(address_imem), 32'(m_pc));
        check("fd_insn", fd_insn, m_fi);
        check("fd_pc", 32'(fd_pc), 32'(m_fp));
        check("fd_valid", 32'(fd_valid), 32'(m_fv));
`ifdef FETCH_PERF_EN
        check("perf_fetched", perf_fetched, m_nf);
        check("perf_stalls", perf_stalls, m_ns);
        check("perf_flushes", perf_flushes, m_nr);
`endif
    endtask
    initial begin
        for (int i = 0; i < 4096; i++) imem[i] = $urandom;
        imem[0] = 32'h0A000005;
        imem[1] = 32'h00000000;
        imem[2] = 32'h28C40001;
        imem[3] = 32'hB0000000;
        @(negedge clock);
        step(1, 0, 0, 0);
        check("reset_addr", 32'(address_imem), 32'h0);
        check("reset_valid", 32'(fd_valid), 32'h0);
        check("reset_insn", fd_insn, 32'h0);
        step(0, 0, 0, 0);
        check("first_insn", fd_insn, 32'h0A000005);
        check("first_pc", 32'(fd_pc), 32'h1);
        check("first_valid", 32'(fd_valid), 32'h1);
        step(0, 0, 0, 0);
        check("pc_at_2", 32'(address_imem), 32'h2);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        check("stall_addr", 32'(address_imem), 32'h2);
        check("stall_pc", 32'(fd_pc), 32'h2);
        check("stall_insn", fd_insn, 32'h0);
        step(0, 0, 0, 0);
        check("post_stall_insn", fd_insn, 32'h28C40001);
        check("post_stall_pc", 32'(fd_pc), 32'h3);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        check("pc_at_5", 32'(address_imem), 32'h5);
        step(0, 0, 1, 'h040);
        check("redir_addr", 32'(address_imem), 32'h040);
        check("redir_valid", 32'(fd_valid), 32'h0);
        check("redir_insn", fd_insn, 32'h0);
        step(0, 0, 0, 0);
        check("redir_target_insn", fd_insn, imem[12'h040]);
        check("redir_target_pc", 32'(fd_pc), 32'h041);
        step(0, 1, 1, 'h010);
        check("redir_stall_addr", 32'(address_imem), 32'h010);
        check("redir_stall_valid", 32'(fd_valid), 32'h0);
        step(0, 0, 1, 'hFFF);
        step(0, 0, 0, 0);
        check("wrap_addr", 32'(address_imem), 32'h0);
        check("wrap_pc", 32'(fd_pc), 32'h0);
        step(0, 1, 0, 0);
        step(1, 1, 0, 0);
        check("reset_in_stall_addr", 32'(address_imem), 32'h0);
        check("reset_in_stall_valid", 32'(fd_valid), 32'h0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 1, 0, 0);
        step(0, 1, 0, 0);
        step(0, 0, 1, 'h123);
`ifdef FETCH_PERF_EN
        check("perf3_fetched", perf_fetched, 32'd3);
        check("perf3_stalls", perf_stalls, 32'd2);
        check("perf3_flushes", perf_flushes, 32'd1);
`endif
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(99) < 2, $urandom_range(99) < 25,
                 $urandom_range(99) < 15, int'($urandom_range(4095)));
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
